// File: rtl/bldc_gate_pkg.sv
// Shared types and helpers for the BLDC gate-driver supervision blocks.
package bldc_gate_pkg;

  // Supervisor states for one gate driver.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_RESET_REQ  = 3'd2,
    ST_RESET_WAIT = 3'd3,
    ST_SETTLE     = 3'd4,
    ST_LOCKOUT    = 3'd5
  } gate_fault_state_t;

  // Converts a duration in microseconds to clock ticks. A zero result is
  // raised to one tick so every timed phase lasts at least one cycle.
  function automatic int unsigned us_to_ticks(input int unsigned freq_hz,
                                              input int unsigned time_us);
    int unsigned ticks;
    ticks = (freq_hz / 32'd1_000_000) * time_us;
    if (ticks == 32'd0) begin
      ticks = 32'd1;
    end else begin
      ticks = ticks;
    end
    return ticks;
  endfunction

endpackage

// File: rtl/fault_pin_filter.sv
// Two-flop synchronizer plus symmetric glitch filter for the active-low
// nFAULT pin. The filtered level only changes after the synchronized pin
// has disagreed with it for filter_ticks consecutive cycles.
module fault_pin_filter
  import bldc_gate_pkg::*;
#(
  parameter int unsigned filter_ticks = 108
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin_n,
  output logic o_fault
);

  localparam int unsigned TICKS = (filter_ticks == 32'd0) ? 32'd1 : filter_ticks;
  localparam int unsigned CW    = $clog2(TICKS + 32'd1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS - 32'd1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_fault;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_fault_nxt;
  logic          w_level_fault;

  assign w_level_fault = ~r_sync2;
  assign o_fault       = r_fault;

  // Bring the asynchronous pin into the clock domain; idle level is "no fault".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pin_n;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    w_cnt_nxt   = CNT_ZERO;
    w_fault_nxt = r_fault;
    if (w_level_fault != r_fault) begin
      if (r_cnt == CNT_LAST) begin
        w_fault_nxt = w_level_fault;
        w_cnt_nxt   = CNT_ZERO;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_ONE;
      end
    end else begin
      w_cnt_nxt = CNT_ZERO;
    end
  end

  // Hold the filter counter and the filtered fault level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= CNT_ZERO;
      r_fault <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_fault <= w_fault_nxt;
    end
  end

endmodule

// File: rtl/gate_driver_fault_ctrl.sv
// Gate-driver fault supervisor: filters nFAULT, requests fast then slow
// resets from the downstream reset block, and latches a lockout once the
// retry budget is spent. All outputs are registered from the next state so
// they change on the same edge as the state itself.
module gate_driver_fault_ctrl
  import bldc_gate_pkg::*;
#(
  parameter int unsigned clk_freq_hz  = 54_000_000,
  parameter int unsigned filter_us    = 2,
  parameter int unsigned settle_us    = 50,
  parameter int unsigned healthy_us   = 1000,
  parameter int unsigned fast_retries = 2,
  parameter int unsigned max_retries  = 4
) (
  input  logic                             sys_clk,
  input  logic                             reset_n,
  input  logic                             enable_req,
  input  logic                             n_fault,
  input  logic                             clear_lockout,
  input  logic                             reset_done,
  output logic                             driver_enable,
  output logic                             reset_start,
  output logic                             slow_reset,
  output logic                             fault_active,
  output logic                             lockout,
  output logic [$clog2(max_retries+1)-1:0] retry_count
);

  localparam int unsigned FILTER_TICKS  = us_to_ticks(clk_freq_hz, filter_us);
  localparam int unsigned SETTLE_TICKS  = us_to_ticks(clk_freq_hz, settle_us);
  localparam int unsigned HEALTHY_TICKS = us_to_ticks(clk_freq_hz, healthy_us);

  localparam int unsigned RW = $clog2(max_retries + 32'd1);
  localparam int unsigned SW = $clog2(SETTLE_TICKS + 32'd1);
  localparam int unsigned HW = $clog2(HEALTHY_TICKS + 32'd1);

  localparam logic [RW-1:0] RETRY_ZERO   = RW'(0);
  localparam logic [RW-1:0] RETRY_ONE    = RW'(1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(max_retries);
  localparam logic [RW-1:0] RETRY_FAST   = RW'(fast_retries);
  localparam logic [SW-1:0] PHASE_ZERO   = SW'(0);
  localparam logic [SW-1:0] PHASE_ONE    = SW'(1);
  localparam logic [SW-1:0] PHASE_SAT    = {SW{1'b1}};
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_TICKS - 32'd1);
  localparam logic [HW-1:0] HEALTHY_ZERO = HW'(0);
  localparam logic [HW-1:0] HEALTHY_ONE  = HW'(1);
  localparam logic [HW-1:0] HEALTHY_LAST = HW'(HEALTHY_TICKS - 32'd1);

  gate_fault_state_t r_state;
  gate_fault_state_t w_state_nxt;
  logic [RW-1:0]     r_retry;
  logic [RW-1:0]     w_retry_nxt;
  logic [SW-1:0]     r_phase;
  logic [SW-1:0]     w_phase_nxt;
  logic [HW-1:0]     r_healthy;
  logic [HW-1:0]     w_healthy_nxt;
  logic              r_driver_enable;
  logic              r_reset_start;
  logic              r_slow_reset;
  logic              r_lockout;
  logic              w_enable_nxt;
  logic              w_start_nxt;
  logic              w_slow_nxt;
  logic              w_lockout_nxt;
  logic              w_fault;
  logic              w_wait_armed;

  fault_pin_filter #(
    .filter_ticks (FILTER_TICKS)
  ) u_fault_pin_filter (
    .i_clk   (sys_clk),
    .i_rst_n (reset_n),
    .i_pin_n (n_fault),
    .o_fault (w_fault)
  );

  // The reset block drops reset_done one cycle after the start pulse, so the
  // first RESET_WAIT cycle (phase 0) must not look at it.
  assign w_wait_armed = (r_phase != PHASE_ZERO);

  // Next-state, retry bookkeeping and timed-phase counters.
  always_comb begin
    w_state_nxt   = r_state;
    w_retry_nxt   = r_retry;
    w_healthy_nxt = HEALTHY_ZERO;
    w_phase_nxt   = PHASE_ZERO;
    w_slow_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_retry_nxt = RETRY_ZERO;
        if (enable_req) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable_req) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = RETRY_ZERO;
        end else if (w_fault) begin
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = ST_LOCKOUT;
          end else begin
            w_state_nxt = ST_RESET_REQ;
          end
        end else if (r_healthy == HEALTHY_LAST) begin
          w_retry_nxt   = RETRY_ZERO;
          w_healthy_nxt = HEALTHY_ZERO;
        end else begin
          w_healthy_nxt = r_healthy + HEALTHY_ONE;
        end
      end
      ST_RESET_REQ: begin
        if (!enable_req) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = RETRY_ZERO;
        end else begin
          w_state_nxt = ST_RESET_WAIT;
        end
      end
      ST_RESET_WAIT: begin
        if (!enable_req) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = RETRY_ZERO;
        end else if (w_wait_armed && reset_done) begin
          w_state_nxt = ST_SETTLE;
        end else begin
          w_state_nxt = ST_RESET_WAIT;
        end
      end
      ST_SETTLE: begin
        if (!enable_req) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = RETRY_ZERO;
        end else if (r_phase == SETTLE_LAST) begin
          if (!w_fault) begin
            w_state_nxt = ST_RUN;
          end else if (r_retry == RETRY_MAX) begin
            w_state_nxt = ST_LOCKOUT;
          end else begin
            w_state_nxt = ST_RESET_REQ;
          end
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_LOCKOUT: begin
        if (clear_lockout) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = RETRY_ZERO;
        end else begin
          w_state_nxt = ST_LOCKOUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_retry_nxt = RETRY_ZERO;
      end
    endcase

    // Issuing a reset: pick its type from the count before this reset, then count it.
    if (w_state_nxt == ST_RESET_REQ) begin
      w_slow_nxt = (r_retry >= RETRY_FAST);
      if (r_retry != RETRY_MAX) begin
        w_retry_nxt = r_retry + RETRY_ONE;
      end else begin
        w_retry_nxt = r_retry;
      end
    end else begin
      w_slow_nxt = 1'b0;
    end

    // Phase counter restarts on every state change and saturates otherwise.
    if (w_state_nxt != r_state) begin
      w_phase_nxt = PHASE_ZERO;
    end else if (r_phase != PHASE_SAT) begin
      w_phase_nxt = r_phase + PHASE_ONE;
    end else begin
      w_phase_nxt = r_phase;
    end
  end

  // Output decode from the upcoming state.
  always_comb begin
    w_enable_nxt  = 1'b0;
    w_start_nxt   = 1'b0;
    w_lockout_nxt = 1'b0;
    case (w_state_nxt)
      ST_RUN, ST_RESET_WAIT, ST_SETTLE: begin
        w_enable_nxt = 1'b1;
      end
      ST_RESET_REQ: begin
        w_enable_nxt = 1'b1;
        w_start_nxt  = 1'b1;
      end
      ST_LOCKOUT: begin
        w_lockout_nxt = 1'b1;
      end
      default: begin
        w_enable_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_retry         <= RETRY_ZERO;
      r_phase         <= PHASE_ZERO;
      r_healthy       <= HEALTHY_ZERO;
      r_driver_enable <= 1'b0;
      r_reset_start   <= 1'b0;
      r_slow_reset    <= 1'b0;
      r_lockout       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_retry         <= w_retry_nxt;
      r_phase         <= w_phase_nxt;
      r_healthy       <= w_healthy_nxt;
      r_driver_enable <= w_enable_nxt;
      r_reset_start   <= w_start_nxt;
      r_slow_reset    <= w_slow_nxt;
      r_lockout       <= w_lockout_nxt;
    end
  end

  assign driver_enable = r_driver_enable;
  assign reset_start   = r_reset_start;
  assign slow_reset    = r_slow_reset;
  assign fault_active  = w_fault;
  assign lockout       = r_lockout;
  assign retry_count   = r_retry;

endmodule

// File: tb/tb_gate_driver_fault_ctrl.sv
// Directed bench for gate_driver_fault_ctrl at a 4 MHz clock:
// filter 8 ticks, settle 200 ticks, healthy 4000 ticks, 2 fast / 4 total retries.
module tb_gate_driver_fault_ctrl;

  localparam int FILTER_T  = 8;
  localparam int SETTLE_T  = 200;
  localparam int HEALTHY_T = 4000;

  logic       sys_clk;
  logic       reset_n;
  logic       enable_req;
  logic       n_fault;
  logic       clear_lockout;
  logic       reset_done;
  logic       driver_enable;
  logic       reset_start;
  logic       slow_reset;
  logic       fault_active;
  logic       lockout;
  logic [2:0] retry_count;

  int n_checks;
  int n_fail;
  int rb_busy;
  int rb_cnt;
  int rs_total;
  int rs_wide;

  gate_driver_fault_ctrl #(
    .clk_freq_hz  (4_000_000),
    .filter_us    (2),
    .settle_us    (50),
    .healthy_us   (1000),
    .fast_retries (2),
    .max_retries  (4)
  ) dut (
    .sys_clk       (sys_clk),
    .reset_n       (reset_n),
    .enable_req    (enable_req),
    .n_fault       (n_fault),
    .clear_lockout (clear_lockout),
    .reset_done    (reset_done),
    .driver_enable (driver_enable),
    .reset_start   (reset_start),
    .slow_reset    (slow_reset),
    .fault_active  (fault_active),
    .lockout       (lockout),
    .retry_count   (retry_count)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Downstream reset block: drops reset_done on a start pulse, raises it rb_busy cycles later.
  initial begin
    reset_done = 1'b1;
    rb_cnt     = 0;
    forever begin
      @(negedge sys_clk);
      if (reset_start) begin
        rb_cnt     = rb_busy;
        reset_done = 1'b0;
      end else if (rb_cnt > 0) begin
        rb_cnt = rb_cnt - 1;
        if (rb_cnt == 0) reset_done = 1'b1;
      end
    end
  end

  // Pulse monitor: total reset_start pulses and any pulse wider than one cycle.
  initial begin
    logic prev;
    prev     = 1'b0;
    rs_total = 0;
    rs_wide  = 0;
    forever begin
      @(negedge sys_clk);
      if (reset_start && !prev) rs_total = rs_total + 1;
      if (reset_start && prev) rs_wide = rs_wide + 1;
      prev = reset_start;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Waits (bounded) for a reset_start pulse; leaves time at the negedge it is seen.
  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge sys_clk);
      if (reset_start) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++; if (driver_enable !== 1'b0) begin n_fail++; $display("FAIL reset_driver_enable got %b want 0", driver_enable); end
    n_checks++; if (reset_start !== 1'b0) begin n_fail++; $display("FAIL reset_reset_start got %b want 0", reset_start); end
    n_checks++; if (slow_reset !== 1'b0) begin n_fail++; $display("FAIL reset_slow_reset got %b want 0", slow_reset); end
    n_checks++; if (fault_active !== 1'b0) begin n_fail++; $display("FAIL reset_fault_active got %b want 0", fault_active); end
    n_checks++; if (lockout !== 1'b0) begin n_fail++; $display("FAIL reset_lockout got %b want 0", lockout); end
    n_checks++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL reset_retry_count got %0d want 0", retry_count); end
    reset_n = 1'b1;
    cyc(3);
    n_checks++; if (driver_enable !== 1'b0) begin n_fail++; $display("FAIL idle_no_enable got %b want 0", driver_enable); end
  endtask

  task automatic test_enable();
    enable_req = 1'b1;
    cyc(1);
    n_checks++; if (driver_enable !== 1'b1) begin n_fail++; $display("FAIL enable_to_run got %b want 1", driver_enable); end
    clear_lockout = 1'b1;
    cyc(1);
    clear_lockout = 1'b0;
    cyc(2);
    n_checks++; if (driver_enable !== 1'b1 || lockout !== 1'b0) begin n_fail++; $display("FAIL clear_outside_lockout got en=%b lock=%b want en=1 lock=0", driver_enable, lockout); end
  endtask

  task automatic test_glitch();
    int start0;
    bit fa_seen;
    start0  = rs_total;
    fa_seen = 1'b0;
    n_fault = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      if (fault_active) fa_seen = 1'b1;
    end
    n_fault = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge sys_clk);
      if (fault_active) fa_seen = 1'b1;
    end
    n_checks++; if (fa_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_fault_active got %b want 0", fa_seen); end
    n_checks++; if (rs_total - start0 != 0) begin n_fail++; $display("FAIL glitch_reset_start got %0d pulses want 0", rs_total - start0); end
  endtask

  task automatic test_single_fault();
    int lat;
    int start0;
    start0  = rs_total;
    lat     = -1;
    n_fault = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge sys_clk);
      if (fault_active) begin
        lat = c;
        break;
      end
    end
    n_checks++; if (lat != FILTER_T + 2) begin n_fail++; $display("FAIL fault_latency got %0d cycles want %0d", lat, FILTER_T + 2); end
    n_checks++; if (reset_start !== 1'b0) begin n_fail++; $display("FAIL start_not_early got %b want 0", reset_start); end
    cyc(1);
    n_checks++; if (reset_start !== 1'b1) begin n_fail++; $display("FAIL single_reset_start got %b want 1", reset_start); end
    n_checks++; if (slow_reset !== 1'b0) begin n_fail++; $display("FAIL single_slow_reset got %b want 0", slow_reset); end
    n_checks++; if (retry_count !== 3'd1) begin n_fail++; $display("FAIL single_retry got %0d want 1", retry_count); end
    cyc(1);
    n_checks++; if (reset_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width got %b want 0", reset_start); end
    n_fault = 1'b1;
    cyc(rb_busy + SETTLE_T + HEALTHY_T - 1);
    n_checks++; if (driver_enable !== 1'b1 || retry_count !== 3'd1) begin n_fail++; $display("FAIL healthy_before got en=%b retry=%0d want en=1 retry=1", driver_enable, retry_count); end
    cyc(1);
    n_checks++; if (retry_count !== 3'd0) begin n_fail++; $display("FAIL healthy_clear got %0d want 0", retry_count); end
    n_checks++; if (rs_total - start0 != 1) begin n_fail++; $display("FAIL single_pulse_count got %0d want 1", rs_total - start0); end
  endtask

  task automatic test_escalation();
    int   t_p [4];
    logic s_p [4];
    logic [2:0] r_p [4];
    logic exp_slow [4];
    int   pulses;
    exp_slow = '{1'b0, 1'b0, 1'b1, 1'b1};
    pulses   = 0;
    n_fault  = 1'b0;
    for (int c = 0; c < 2000 && pulses < 4; c++) begin
      @(negedge sys_clk);
      if (reset_start) begin
        t_p[pulses] = c;
        s_p[pulses] = slow_reset;
        r_p[pulses] = retry_count;
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL esc_pulses got %0d want 4", pulses);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (s_p[k] !== exp_slow[k]) begin n_fail++; $display("FAIL esc_slow_%0d got %b want %b", k + 1, s_p[k], exp_slow[k]); end
      n_checks++; if (r_p[k] !== 3'(k + 1)) begin n_fail++; $display("FAIL esc_retry_%0d got %0d want %0d", k + 1, r_p[k], k + 1); end
    end
    for (int k = 1; k < 4; k++) begin
      n_checks++; if (t_p[k] - t_p[k-1] != rb_busy + 1 + SETTLE_T) begin n_fail++; $display("FAIL esc_interval_%0d got %0d want %0d", k, t_p[k] - t_p[k-1], rb_busy + 1 + SETTLE_T); end
    end
    cyc(rb_busy + SETTLE_T);
    n_checks++; if (lockout !== 1'b0 || driver_enable !== 1'b1) begin n_fail++; $display("FAIL esc_settle_end got lock=%b en=%b want lock=0 en=1", lockout, driver_enable); end
    cyc(1);
    n_checks++; if (lockout !== 1'b1) begin n_fail++; $display("FAIL esc_lockout got %b want 1", lockout); end
    n_checks++; if (driver_enable !== 1'b0) begin n_fail++; $display("FAIL esc_lockout_en got %b want 0", driver_enable); end
    n_checks++; if (retry_count !== 3'd4) begin n_fail++; $display("FAIL esc_lockout_retry got %0d want 4", retry_count); end
  endtask

  task automatic test_lockout_exit();
    int start0;
    start0     = rs_total;
    enable_req = 1'b0;
    n_fault    = 1'b1;
    cyc(20);
    n_checks++; if (lockout !== 1'b1 || driver_enable !== 1'b0 || retry_count !== 3'd4) begin n_fail++; $display("FAIL lockout_sticky got lock=%b en=%b retry=%0d want 1 0 4", lockout, driver_enable, retry_count); end
    n_checks++; if (rs_total - start0 != 0) begin n_fail++; $display("FAIL lockout_no_start got %0d want 0", rs_total - start0); end
    enable_req    = 1'b1;
    clear_lockout = 1'b1;
    cyc(1);
    clear_lockout = 1'b0;
    n_checks++; if (lockout !== 1'b0 || driver_enable !== 1'b0 || retry_count !== 3'd0) begin n_fail++; $display("FAIL clear_to_idle got lock=%b en=%b retry=%0d want 0 0 0", lockout, driver_enable, retry_count); end
    cyc(1);
    n_checks++; if (driver_enable !== 1'b1) begin n_fail++; $display("FAIL idle_to_run got %b want 1", driver_enable); end
  endtask

  task automatic test_enable_wins();
    bit seen;
    int start0;
    seen    = 1'b0;
    n_fault = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge sys_clk);
      if (fault_active) begin
        seen = 1'b1;
        break;
      end
    end
    start0     = rs_total;
    enable_req = 1'b0;
    cyc(1);
    n_checks++; if (seen !== 1'b1 || driver_enable !== 1'b0 || reset_start !== 1'b0) begin n_fail++; $display("FAIL enable_wins got seen=%b en=%b start=%b want 1 0 0", seen, driver_enable, reset_start); end
    n_fault = 1'b1;
    cyc(20);
    n_checks++; if (rs_total - start0 != 0) begin n_fail++; $display("FAIL enable_wins_pulses got %0d want 0", rs_total - start0); end
    enable_req = 1'b1;
    cyc(1);
    n_checks++; if (driver_enable !== 1'b1 || retry_count !== 3'd0) begin n_fail++; $display("FAIL enable_wins_rerun got en=%b retry=%0d want 1 0", driver_enable, retry_count); end
  endtask

  task automatic test_disable_mid_reset();
    bit found;
    int start0;
    bit en_seen;
    rb_busy = 60;
    n_fault = 1'b0;
    wait_start(40, found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL mid_reset_start got none want pulse"); end
    n_fault = 1'b1;
    cyc(3);
    n_checks++; if (retry_count !== 3'd1 || driver_enable !== 1'b1 || reset_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wait got retry=%0d en=%b done=%b want 1 1 0", retry_count, driver_enable, reset_done); end
    enable_req = 1'b0;
    cyc(1);
    n_checks++; if (driver_enable !== 1'b0 || retry_count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_idle got en=%b retry=%0d want 0 0", driver_enable, retry_count); end
    start0  = rs_total;
    en_seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge sys_clk);
      if (driver_enable) en_seen = 1'b1;
    end
    n_checks++; if (en_seen !== 1'b0 || rs_total - start0 != 0) begin n_fail++; $display("FAIL late_done_ignored got en=%b pulses=%0d want 0 0", en_seen, rs_total - start0); end
    rb_busy    = 20;
    enable_req = 1'b1;
    cyc(1);
    n_checks++; if (driver_enable !== 1'b1) begin n_fail++; $display("FAIL mid_reset_rerun got %b want 1", driver_enable); end
  endtask

  task automatic test_async_reset_settle();
    bit found;
    n_fault = 1'b0;
    wait_start(40, found);
    n_fault = 1'b1;
    cyc(70);
    n_checks++; if (found !== 1'b1 || driver_enable !== 1'b1 || retry_count !== 3'd1) begin n_fail++; $display("FAIL settle_precond got found=%b en=%b retry=%0d want 1 1 1", found, driver_enable, retry_count); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({driver_enable, reset_start, slow_reset, fault_active, lockout, retry_count} !== 8'h00) begin n_fail++; $display("FAIL async_reset got en=%b st=%b sl=%b fa=%b lk=%b retry=%0d want all 0", driver_enable, reset_start, slow_reset, fault_active, lockout, retry_count); end
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_pulse_width();
    n_checks++; if (rs_wide != 0) begin n_fail++; $display("FAIL pulse_width got %0d wide cycles want 0", rs_wide); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rb_busy       = 20;
    reset_n       = 1'b0;
    enable_req    = 1'b0;
    n_fault       = 1'b1;
    clear_lockout = 1'b0;
    cyc(3);
    test_reset();
    test_enable();
    test_glitch();
    test_single_fault();
    test_escalation();
    test_lockout_exit();
    test_enable_wins();
    test_disable_mid_reset();
    test_async_reset_settle();
    test_pulse_width();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
